// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// Module      : ram_fifo_pkg
// Description : Shared constants and helpers for the RAM-backed FIFO
//               controller (skid-buffer depth, pointer wrap, level width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

    // Output skid buffer depth. The read-issue rule and the 1-bit indices
    // inside ram_fifo_obuf both assume exactly two entries.
    localparam int OBUF_DEPTH = 2;

    // Advance a circular pointer, wrapping depth-1 -> 0.
    function automatic int unsigned next_ptr(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    // Width of the level count. It must hold DEPTH + OBUF_DEPTH, where
    // DEPTH = 2**awid.
    function automatic int level_w(input int awid);
        return awid + 2;
    endfunction

    // Level count type for the default geometry (AWID = 8).
    typedef logic [level_w(8)-1:0] level_t;

endpackage

`default_nettype wire

// File: rtl/ram_fifo_obuf.sv
// ============================================================================
// Module      : ram_fifo_obuf
// Description : Two-entry skid buffer that captures registered RAM read data
//               and presents the FIFO head. Supports capture and pop in the
//               same cycle. clr empties it and drops a same-cycle capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_obuf
    import ram_fifo_pkg::*;
#(
    parameter int DWID = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic [DWID-1:0] push_data,
    input  logic            pop,
    output logic            valid,
    output logic [DWID-1:0] data,
    output logic [1:0]      cnt
);

    // The 1-bit head/tail indices are sized for OBUF_DEPTH == 2.
    logic [DWID-1:0] r_mem [OBUF_DEPTH];
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_cnt;
    logic            w_push;

    // Capture is suppressed during a clear, so an in-flight word is dropped.
    assign w_push = push & ~clr;

    // Storage has no reset. Only the occupancy bookkeeping decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= push_data;
        end
    end

    // Head/tail indices and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, pop};
        end
    end

    assign valid = (r_cnt != 2'd0);
    assign data  = r_mem[r_head];
    assign cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Valid/ready streaming FIFO built on a dual-port RAM (ram2p).
//               Port A is the write port and port B is the read port. Reads
//               are issued ahead into a 2-entry skid buffer. This hides the
//               1-cycle registered read latency and sustains 1 word/cycle.
// Options     : `define RAM_FIFO_CTRL_FLUSH_EN adds a synchronous 'flush'
//               input that empties the FIFO for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWID-1:0]   wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWID-1:0]   rd_data,
    output logic [AWID+1:0]   level,
    output logic              a_we,
    output logic [AWID-1:0]   a_addr,
    output logic [DWID-1:0]   a_din,
    output logic              b_we,
    output logic [AWID-1:0]   b_addr,
    input  logic [DWID-1:0]   b_dout
);

    typedef logic [level_w(AWID)-1:0] lvl_t;

    localparam logic [AWID:0] C_DEPTH = (AWID+1)'(DEPTH);

    logic [AWID-1:0] r_wr_ptr;
    logic [AWID-1:0] r_rd_ptr;
    logic [AWID:0]   r_ram_words;
    logic            r_inflight;

    logic            w_flush;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_obuf_valid;
    logic [1:0]      w_obuf_cnt;
    logic [2:0]      w_obuf_need;
    lvl_t            w_level;

`ifdef RAM_FIFO_CTRL_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Write side: the RAM write goes straight from the upstream handshake.
    assign wr_ready = rst_n & ~w_flush & (r_ram_words != C_DEPTH);
    assign w_push   = wr_valid & wr_ready;
    assign a_we     = w_push;
    assign a_addr   = rst_n ? r_wr_ptr : '0;
    assign a_din    = wr_data;

    // Read side: port B is read-only.
    assign b_we     = 1'b0;
    assign b_addr   = rst_n ? r_rd_ptr : '0;
    assign rd_valid = rst_n & w_obuf_valid;
    assign w_pop    = rd_valid & rd_ready;

    // Skid slots already committed once this cycle's pop retires. Issue a
    // read only if a slot is left for it. pop implies obuf_cnt >= 1, so the
    // subtraction cannot underflow.
    assign w_obuf_need = {1'b0, w_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = rst_n & ~w_flush & (r_ram_words != '0) & (w_obuf_need <= 3'd1);

    // Pointers, RAM occupancy and the one-deep read-in-flight flag.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_words <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= AWID'(next_ptr(32'(r_wr_ptr), 32'(DEPTH)));
            end
            if (w_issue) begin
                r_rd_ptr <= AWID'(next_ptr(32'(r_rd_ptr), 32'(DEPTH)));
            end
            r_ram_words <= r_ram_words + {{AWID{1'b0}}, w_push}
                                       - {{AWID{1'b0}}, w_issue};
            r_inflight  <= w_issue;
        end
    end

    // b_dout is valid in the cycle after the read is issued. It is captured
    // at the end of that cycle.
    ram_fifo_obuf #(
        .DWID (DWID)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_flush),
        .push      (r_inflight),
        .push_data (b_dout),
        .pop       (w_pop),
        .valid     (w_obuf_valid),
        .data      (rd_data),
        .cnt       (w_obuf_cnt)
    );

    // level counts every word held: in RAM, in the read pipe and in the
    // skid buffer.
    assign w_level = lvl_t'(r_ram_words) + lvl_t'(r_inflight) + lvl_t'(w_obuf_cnt);
    assign level   = rst_n ? w_level : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Directed self-checking bench for ram_fifo_ctrl (DEPTH=4)
//               with a behavioural ram2p model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int AWID  = 2;
    localparam int DWID  = 16;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            wr_valid = 1'b0;
    logic [DWID-1:0] wr_data  = '0;
    logic            rd_ready = 1'b0;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    logic            flush    = 1'b0;
`endif
    logic            wr_ready;
    logic            rd_valid;
    logic [DWID-1:0] rd_data;
    logic [AWID+1:0] level;
    logic            a_we;
    logic [AWID-1:0] a_addr;
    logic [DWID-1:0] a_din;
    logic            b_we;
    logic [AWID-1:0] b_addr;
    logic [DWID-1:0] b_dout;

    int              n_chk  = 0;
    int              n_fail = 0;
    int              n_acc  = 0;
    int              n_pop  = 0;
    int              base;
    logic [DWID-1:0] q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DEPTH(DEPTH), .AWID(AWID), .DWID(DWID)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef RAM_FIFO_CTRL_FLUSH_EN
        .flush    (flush),
`endif
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_dout   (b_dout)
    );

    // ram2p model: synchronous write on A, registered read on B
    logic [DWID-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        b_dout <= mem[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at posedge+1, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [DWID-1:0] d, input logic rr);
        wr_valid = v;
        wr_data  = d;
        rd_ready = rr;
        #1;
    endtask

    // Scoreboard the handshakes of the current cycle, then advance one clock.
    task automatic cyc();
        if (rd_valid) begin
            check("valid_has_data", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("head_data", 32'(rd_data), 32'(q[0]));
        end
        if (rd_valid && rd_ready && q.size() != 0) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (wr_valid && wr_ready) begin
            q.push_back(wr_data);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            drive(1'b0, '0, 1'b1);
            if (!rd_valid && q.size() == 0) break;
            cyc();
        end
        check("drain_qsize", 32'(q.size()), 32'd0);
        check("drain_level", 32'(level), 32'd0);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        @(posedge clk); #1;
        drive(1'b1, 16'hFFFF, 1'b1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_a_we", 32'(a_we), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        check("b_we_tied", 32'(b_we), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        q.delete();

        // ---------------- single word latency ----------------
        drive(1'b1, 16'hA001, 1'b0);
        check("t1_wr_ready", 32'(wr_ready), 32'd1);
        check("t1_a_we", 32'(a_we), 32'd1);
        check("t1_a_addr", 32'(a_addr), 32'd0);
        check("t1_level0", 32'(level), 32'd0);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t1_c1_rd_valid", 32'(rd_valid), 32'd0);
        check("t1_c1_level", 32'(level), 32'd1);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t1_c2_rd_valid", 32'(rd_valid), 32'd0);
        check("t1_c2_level", 32'(level), 32'd1);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t1_c3_rd_valid", 32'(rd_valid), 32'd1);
        check("t1_c3_rd_data", 32'(rd_data), 32'hA001);
        check("t1_c3_level", 32'(level), 32'd1);
        cyc();
        drive(1'b0, '0, 1'b1);
        check("t1_hold_data", 32'(rd_data), 32'hA001);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t1_empty_valid", 32'(rd_valid), 32'd0);
        check("t1_empty_level", 32'(level), 32'd0);

        // ---------------- fill to full, then drain ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(i + 1), 1'b0);
            check("t2_wr_ready", 32'(wr_ready), 32'd1);
            cyc();
        end
        drive(1'b1, 16'h0007, 1'b0);
        check("t2_full_wr_ready", 32'(wr_ready), 32'd0);
        check("t2_full_a_we", 32'(a_we), 32'd0);
        check("t2_full_level", 32'(level), 32'd6);
        cyc();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1);
            check("t2_pop_valid", 32'(rd_valid), 32'd1);
            check("t2_pop_data", 32'(rd_data), 32'(i + 1));
            cyc();
        end
        drive(1'b0, '0, 1'b0);
        check("t2_end_valid", 32'(rd_valid), 32'd0);
        check("t2_end_level", 32'(level), 32'd0);

        // ---------------- continuous streaming ----------------
        base = n_pop;
        for (int c = 0; c < 24; c++) begin
            drive(c < 20, 16'(16'h0100 + c), 1'b1);
            if (c < 20) check("t3_wr_ready", 32'(wr_ready), 32'd1);
            check("t3_rd_valid", 32'(rd_valid), 32'((c >= 3) && (c < 23)));
            check("t3_level_le3", 32'(level <= 4'd3), 32'd1);
            cyc();
        end
        check("t3_pops", 32'(n_pop - base), 32'd20);
        check("t3_qsize", 32'(q.size()), 32'd0);

        // ---------------- rd_ready toggling ----------------
        base = n_acc;
        for (int c = 0; c < 200; c++) begin
            if (n_acc - base >= 12) break;
            drive(1'b1, 16'(16'h0200 + (n_acc - base)), (c % 2) == 0);
            cyc();
        end
        check("t4_accepted", 32'(n_acc - base), 32'd12);
        base = n_pop - (12 - q.size());
        drain();
        check("t4_pops", 32'(n_pop - base), 32'd12);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(16'h0300 + i), 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1);
        check("t5_pop_data", 32'(rd_data), 32'h0300);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t5_level_pre", 32'(level), 32'd5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_level", 32'(level), 32'd0);
        check("t5_rst_wr_ready", 32'(wr_ready), 32'd0);
        check("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
        cyc();
        rst_n = 1'b1;
        q.delete();
        drive(1'b0, '0, 1'b0);
        check("t5_post_level", 32'(level), 32'd0);
        check("t5_post_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_post_wr_ready", 32'(wr_ready), 32'd1);
        cyc();
        drive(1'b1, 16'hBEEF, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        check("t5_c2_rd_valid", 32'(rd_valid), 32'd0);
        cyc();
        drive(1'b0, '0, 1'b1);
        check("t5_rd_valid", 32'(rd_valid), 32'd1);
        check("t5_rd_data", 32'(rd_data), 32'hBEEF);
        check("t5_level", 32'(level), 32'd1);
        cyc();
        drive(1'b0, '0, 1'b1);
        check("t5_only_one", 32'(rd_valid), 32'd0);
        drain();

`ifdef RAM_FIFO_CTRL_FLUSH_EN
        // ---------------- flush ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0400 + i), 1'b0);
            cyc();
        end
        flush = 1'b1;
        drive(1'b1, 16'hDEAD, 1'b0);
        check("t6_level_pre", 32'(level), 32'd3);
        check("t6_flush_wr_ready", 32'(wr_ready), 32'd0);
        check("t6_flush_a_we", 32'(a_we), 32'd0);
        cyc();
        flush = 1'b0;
        q.delete();
        drive(1'b0, '0, 1'b0);
        check("t6_post_level", 32'(level), 32'd0);
        check("t6_post_rd_valid", 32'(rd_valid), 32'd0);
        cyc();
        drive(1'b1, 16'h0042, 1'b0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1);
        check("t6_rd_valid", 32'(rd_valid), 32'd1);
        check("t6_rd_data", 32'(rd_data), 32'h0042);
        cyc();
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
